// File: rtl/register_file_sb.sv
// Register file with two bypassed combinational read ports and a per-register
// reservation scoreboard (busy bits plus a running count of busy registers).
module register_file_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [ADDR_W-1:0]         rd_addr_a,
  input  logic [ADDR_W-1:0]         rd_addr_b,
  output logic [WIDTH-1:0]          rd_data_a,
  output logic [WIDTH-1:0]          rd_data_b,
  output logic                      rd_busy_a,
  output logic                      rd_busy_b,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rsv_ack,
  output logic [(2**ADDR_W)-1:0]    busy_vec,
  output logic [ADDR_W:0]           busy_cnt,
  output logic [WIDTH*(2**ADDR_W)-1:0] regs_flat
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  cnt;

  logic wr_zero, rsv_zero, rd_zero_a, rd_zero_b;
  logic wr_eff, hit_a, hit_b, hit_rsv;
  logic set_eff, cnt_inc, cnt_dec;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Counter step that can never wrap in either direction.
  function automatic logic [ADDR_W:0] sat_step(input logic [ADDR_W:0] val,
                                               input logic inc, input logic dec);
    logic [ADDR_W:0] res;
    res = val;
    if (inc && !dec && (val != CNT_FULL))
      res = val + CNT_ONE;
    else if (dec && !inc && (val != '0))
      res = val - CNT_ONE;
    return res;
  endfunction

  always_comb begin
    wr_zero   = is_zero_reg(wr_addr);
    rsv_zero  = is_zero_reg(rsv_addr);
    rd_zero_a = is_zero_reg(rd_addr_a);
    rd_zero_b = is_zero_reg(rd_addr_b);

    wr_eff  = wr_en && !wr_zero;
    hit_a   = wr_en && (wr_addr == rd_addr_a);
    hit_b   = wr_en && (wr_addr == rd_addr_b);
    hit_rsv = wr_en && (wr_addr == rsv_addr);

    // A write landing on a busy register frees it in the same edge, so a
    // reservation racing that write may take it over immediately.
    rsv_ack = !rst && rsv_en && (rsv_zero || !busy[rsv_addr] || hit_rsv);
    set_eff = rsv_ack && !rsv_zero;

    cnt_inc = set_eff && !busy[rsv_addr];
    cnt_dec = wr_eff && busy[wr_addr] && !(set_eff && hit_rsv);

    busy_next = busy;
    if (wr_eff)
      busy_next[wr_addr] = 1'b0;
    if (set_eff)
      busy_next[rsv_addr] = 1'b1;
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!rd_zero_a)
      rd_data_a = hit_a ? wr_data : regs[rd_addr_a];
    if (!rd_zero_b)
      rd_data_b = hit_b ? wr_data : regs[rd_addr_b];
    rd_busy_a = busy[rd_addr_a] && !hit_a;
    rd_busy_b = busy[rd_addr_b] && !hit_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_eff)
        regs[wr_addr] <= wr_data;
      busy <= busy_next;
      cnt  <= sat_step(cnt, cnt_inc, cnt_dec);
    end
  end

  assign busy_vec = busy;
  assign busy_cnt = cnt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign regs_flat[i*WIDTH +: WIDTH] = '0;
    end else begin : g_reg
      assign regs_flat[i*WIDTH +: WIDTH] = regs[i];
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: one instance with a writable r0 and one
// with r0 hardwired to zero, both driven by the same stimulus.
module tb_register_file_sb;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [15:0]  wr_data;
  logic [2:0]   rd_addr_a, rd_addr_b;
  logic         rsv_en;
  logic [2:0]   rsv_addr;

  logic [15:0]  rd_data_a, rd_data_b, z_rd_data_a, z_rd_data_b;
  logic         rd_busy_a, rd_busy_b, z_rd_busy_a, z_rd_busy_b;
  logic         rsv_ack, z_rsv_ack;
  logic [7:0]   busy_vec, z_busy_vec;
  logic [3:0]   busy_cnt, z_busy_cnt;
  logic [127:0] regs_flat, z_regs_flat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  register_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt), .regs_flat(regs_flat)
  );

  register_file_sb #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b),
    .rd_busy_a(z_rd_busy_a), .rd_busy_b(z_rd_busy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(z_rsv_ack),
    .busy_vec(z_busy_vec), .busy_cnt(z_busy_cnt), .regs_flat(z_regs_flat)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; rsv_en = 1'b1; rsv_addr = 3'd1;
    #1;
    chk("ack_in_reset", 128'(rsv_ack), 128'(1'b0));
    tick(); tick();
    rst = 1'b0; rsv_en = 1'b0;
    #1;
    chk("rst_busy_vec", 128'(busy_vec), 128'h0);
    chk("rst_busy_cnt", 128'(busy_cnt), 128'h0);
    chk("rst_regs", regs_flat, 128'h0);

    // write then read r5
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0; rd_addr_a = 3'd5;
    #1;
    chk("rd_a_r5", 128'(rd_data_a), 128'(16'hBEEF));
    chk("flat_r5", 128'(regs_flat[95:80]), 128'(16'hBEEF));
    chk("rd_busy_a_r5", 128'(rd_busy_a), 128'(1'b0));

    // bypass on port b while port a reads r5
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1111;
    tick();
    wr_data = 16'h1234; rd_addr_b = 3'd3;
    #1;
    chk("bypass_b", 128'(rd_data_b), 128'(16'h1234));
    chk("flat_r3_old", 128'(regs_flat[63:48]), 128'(16'h1111));
    chk("rd_a_indep", 128'(rd_data_a), 128'(16'hBEEF));
    tick();
    wr_en = 1'b0;
    #1;
    chk("flat_r3_new", 128'(regs_flat[63:48]), 128'(16'h1234));

    // reservation scoreboard on r2
    rsv_en = 1'b1; rsv_addr = 3'd2;
    #1;
    chk("rsv_r2_ack", 128'(rsv_ack), 128'(1'b1));
    tick();
    rsv_en = 1'b0; rd_addr_a = 3'd2;
    #1;
    chk("rsv_r2_vec", 128'(busy_vec), 128'h04);
    chk("rsv_r2_cnt", 128'(busy_cnt), 128'h1);
    chk("rd_busy_a_r2", 128'(rd_busy_a), 128'(1'b1));
    rsv_en = 1'b1;
    #1;
    chk("rersv_r2_ack", 128'(rsv_ack), 128'(1'b0));
    tick();
    rsv_en = 1'b0;
    #1;
    chk("rersv_r2_vec", 128'(busy_vec), 128'h04);
    chk("rersv_r2_cnt", 128'(busy_cnt), 128'h1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
    #1;
    chk("rd_busy_a_bypass", 128'(rd_busy_a), 128'(1'b0));
    tick();
    wr_en = 1'b0;
    #1;
    chk("wr_r2_vec", 128'(busy_vec), 128'h00);
    chk("wr_r2_cnt", 128'(busy_cnt), 128'h0);

    // simultaneous write and reserve of busy r6
    rsv_en = 1'b1; rsv_addr = 3'd6;
    tick();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'hA5A5;
    #1;
    chk("r6_race_ack", 128'(rsv_ack), 128'(1'b1));
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("r6_race_vec", 128'(busy_vec), 128'h40);
    chk("r6_race_cnt", 128'(busy_cnt), 128'h1);
    chk("r6_race_data", 128'(regs_flat[111:96]), 128'(16'hA5A5));

    // free r6 while reserving r1 in the same edge: count stays at 1
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0606;
    rsv_en = 1'b1; rsv_addr = 3'd1;
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("swap_vec", 128'(busy_vec), 128'h02);
    chk("swap_cnt", 128'(busy_cnt), 128'h1);

    // fill every busy bit, then reset over a concurrent write and reserve
    for (int i = 0; i < 8; i++) begin
      rsv_en = 1'b1; rsv_addr = 3'(i);
      tick();
    end
    rsv_en = 1'b0;
    #1;
    chk("full_vec", 128'(busy_vec), 128'hFF);
    chk("full_cnt", 128'(busy_cnt), 128'h8);
    chk("z_full_vec", 128'(z_busy_vec), 128'hFE);
    chk("z_full_cnt", 128'(z_busy_cnt), 128'h7);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 3'd4;
    #1;
    chk("ack_rst_midseq", 128'(rsv_ack), 128'(1'b0));
    tick();
    rst = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("rst2_vec", 128'(busy_vec), 128'h0);
    chk("rst2_cnt", 128'(busy_cnt), 128'h0);
    chk("rst2_regs", regs_flat, 128'h0);

    // hardwired zero register
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr_a = 3'd0;
    #1;
    chk("z_rd_a_bypass", 128'(z_rd_data_a), 128'h0);
    chk("rd_a_r0_bypass", 128'(rd_data_a), 128'(16'hFFFF));
    tick();
    wr_en = 1'b0;
    #1;
    chk("z_rd_a_after", 128'(z_rd_data_a), 128'h0);
    chk("z_flat_r0", 128'(z_regs_flat[15:0]), 128'h0);
    chk("rd_a_r0_after", 128'(rd_data_a), 128'(16'hFFFF));
    rsv_en = 1'b1; rsv_addr = 3'd0;
    #1;
    chk("z_rsv_r0_ack", 128'(z_rsv_ack), 128'(1'b1));
    tick();
    #1;
    chk("z_rersv_r0_ack", 128'(z_rsv_ack), 128'(1'b1));
    chk("rersv_r0_ack", 128'(rsv_ack), 128'(1'b0));
    rsv_en = 1'b0;
    #1;
    chk("z_r0_vec", 128'(z_busy_vec), 128'h0);
    chk("z_r0_cnt", 128'(z_busy_cnt), 128'h0);
    chk("r0_vec", 128'(busy_vec), 128'h01);
    chk("r0_cnt", 128'(busy_cnt), 128'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
